// File: rtl/noise_filter_ctrl_pkg.sv
// Shared types, widths and default geometry for the noise-filter frame controller.
package noise_filter_ctrl_pkg;

    localparam int unsigned H_PIXELS_DEF  = 320;
    localparam int unsigned V_LINES_DEF   = 240;
    localparam int unsigned CLR_DEPTH_DEF = 320;

    localparam int unsigned X_W         = 9;
    localparam int unsigned Y_W         = 8;
    localparam int unsigned ADDR_W      = 17;
    localparam int unsigned CLR_W       = 9;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ARMED = 2'd2,
        RUN   = 2'd3
    } ctrl_state_e;

    // Raster address as seen by the filter: row in the upper bits, column below.
    function automatic logic [ADDR_W-1:0] pack_pixel_addr(input logic [Y_W-1:0] y,
                                                          input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/noise_filter_frame_ctrl_if.sv
// Config handshake plus filter-facing address/clear bus of the frame controller.
interface noise_filter_frame_ctrl_if;
    import noise_filter_ctrl_pkg::*;

    logic              cfg_valid;
    logic              cfg_enable;
    logic              cfg_ready;
    logic [ADDR_W-1:0] pixel_addr;
    logic              addr_valid;
    logic              clr_we;
    logic [CLR_W-1:0]  clr_addr;

    modport master (
        output cfg_valid, cfg_enable,
        input  cfg_ready, pixel_addr, addr_valid, clr_we, clr_addr
    );

    modport slave (
        input  cfg_valid, cfg_enable,
        output cfg_ready, pixel_addr, addr_valid, clr_we, clr_addr
    );
endinterface

// File: rtl/raster_addr_counter.sv
// x/y raster counters: advance on active pixels, wrap x into y, sync clear at frame boundaries.
module raster_addr_counter
    import noise_filter_ctrl_pkg::*;
#(
    parameter int unsigned H_PIXELS = H_PIXELS_DEF,
    parameter int unsigned V_LINES  = V_LINES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           adv,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           frame_last_c
);

    logic x_last_c;

    assign x_last_c     = (x == X_W'(H_PIXELS - 1));
    assign frame_last_c = x_last_c && (y == Y_W'(V_LINES - 1));

    // y only returns to 0 after the final pixel, never mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (x_last_c) begin
                x <= '0;
                y <= frame_last_c ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/noise_filter_frame_ctrl.sv
// Frame sequencer for the noise filter: line-buffer clear, raster addressing, frame-aligned config.
// Define FILTER_FRAME_CNT_EN to add the frame_count output (completed frames, wrapping).
module noise_filter_frame_ctrl
    import noise_filter_ctrl_pkg::*;
#(
    parameter int unsigned H_PIXELS  = H_PIXELS_DEF,
    parameter int unsigned V_LINES   = V_LINES_DEF,
    parameter int unsigned CLR_DEPTH = CLR_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vsync,
    input  logic                    active_area,
    noise_filter_frame_ctrl_if.slave bus,
    output logic                    filter_enable,
    output logic                    frame_start,
    output logic                    frame_done,
    output logic                    clr_overrun,
    output logic                    busy
`ifdef FILTER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0]  frame_count
`endif
);

    ctrl_state_e       state;
    logic              vsync_d;
    logic              vsync_rise_c;
    logic              cfg_hs_c;
    logic              pix_adv_c;
    logic              frame_last_c;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [CLR_W-1:0]  clr_cnt;

    logic              pending;
    logic              shadow;
    logic              cfg_ready_r;
    logic [ADDR_W-1:0] pixel_addr_r;
    logic              addr_valid_r;
    logic              clr_we_r;
    logic [CLR_W-1:0]  clr_addr_r;

    assign vsync_rise_c = vsync & ~vsync_d;
    assign cfg_hs_c     = bus.cfg_valid & cfg_ready_r;
    assign pix_adv_c    = active_area & ~vsync_rise_c & ((state == ARMED) || (state == RUN));

    assign bus.cfg_ready  = cfg_ready_r;
    assign bus.pixel_addr = pixel_addr_r;
    assign bus.addr_valid = addr_valid_r;
    assign bus.clr_we     = clr_we_r;
    assign bus.clr_addr   = clr_addr_r;

    raster_addr_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES)
    ) u_raster (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (vsync_rise_c),
        .adv          (pix_adv_c),
        .x            (x),
        .y            (y),
        .frame_last_c (frame_last_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_d <= 1'b0;
        else        vsync_d <= vsync;
    end

    // Shadowed enable: a request is held until the next vsync rise, or applied directly if coincident.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= 1'b0;
            shadow        <= 1'b0;
            cfg_ready_r   <= 1'b1;
            filter_enable <= 1'b0;
        end else if (vsync_rise_c) begin
            if (cfg_hs_c)     filter_enable <= bus.cfg_enable;
            else if (pending) filter_enable <= shadow;
            pending     <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else if (cfg_hs_c) begin
            shadow      <= bus.cfg_enable;
            pending     <= 1'b1;
            cfg_ready_r <= 1'b0;
        end
    end

    // Frame FSM with registered strobes; a vsync rise restarts the clear from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clr_cnt      <= '0;
            clr_we_r     <= 1'b0;
            clr_addr_r   <= '0;
            addr_valid_r <= 1'b0;
            pixel_addr_r <= '0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            clr_we_r     <= 1'b0;
            addr_valid_r <= 1'b0;
            if (vsync_rise_c) begin
                frame_start <= 1'b1;
                state       <= CLEAR;
                clr_cnt     <= '0;
                busy        <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: ;
                    CLEAR: begin
                        clr_we_r   <= 1'b1;
                        clr_addr_r <= clr_cnt;
                        if (clr_cnt == CLR_W'(CLR_DEPTH - 1)) begin
                            clr_cnt <= '0;
                            state   <= ARMED;
                        end else begin
                            clr_cnt <= clr_cnt + CLR_W'(1);
                        end
                    end
                    ARMED, RUN: begin
                        if (active_area) begin
                            addr_valid_r <= 1'b1;
                            pixel_addr_r <= pack_pixel_addr(y, x);
                            state        <= RUN;
                            if (frame_last_c) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  clr_overrun <= 1'b0;
        else if ((state == CLEAR) && active_area)    clr_overrun <= 1'b1;
    end

`ifdef FILTER_FRAME_CNT_EN
    // Counts only frames that reach their last pixel; aborted frames never get here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         frame_count <= '0;
        else if (pix_adv_c && frame_last_c) frame_count <= frame_count + FRAME_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_noise_filter_frame_ctrl.sv
// Directed self-checking bench for noise_filter_frame_ctrl (320x240 frame, 320-entry clear).
module tb_noise_filter_frame_ctrl;
    import noise_filter_ctrl_pkg::*;

    localparam int H    = 320;
    localparam int V    = 240;
    localparam int CLR  = 320;
    localparam int NPIX = H * V;

    logic clk = 1'b0;
    logic rst_n;
    logic vsync;
    logic active_area;
    logic filter_enable;
    logic frame_start;
    logic frame_done;
    logic clr_overrun;
    logic busy;
`ifdef FILTER_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    noise_filter_frame_ctrl_if bus ();

    noise_filter_frame_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .active_area   (active_area),
        .bus           (bus),
        .filter_enable (filter_enable),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .clr_overrun   (clr_overrun),
        .busy          (busy)
`ifdef FILTER_FRAME_CNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {y,x} for the idx-th pixel of a frame: y sits at bit 9.
    function automatic int exp_addr(input int idx);
        return (idx / H) * 512 + (idx % H);
    endfunction

    task automatic sample(inout int bad, inout int nvalid, inout int ndone, inout int done_idx);
        if (bus.addr_valid === 1'b1) begin
            if (bus.pixel_addr !== 17'(exp_addr(nvalid))) bad++;
            nvalid++;
        end
        if (frame_done === 1'b1) begin
            ndone++;
            done_idx = nvalid;
        end
    endtask

    // vsync rise then clear; vsync held high 2 extra cycles; optional early stop or overrun pulse.
    task automatic vsync_clear(input int stop_at, input int overrun_at, input logic exp_fe);
        int bad;
        bad = 0;
        vsync = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        check("frame_start", frame_start, 1);
        check("fe_boundary", filter_enable, exp_fe);
        check("cfg_ready_bnd", bus.cfg_ready, 1);
        check("no_done_at_rise", frame_done, 0);
        check("busy_clr", busy, 1);
        for (int i = 0; i < CLR; i++) begin
            if (i == stop_at) begin
                active_area = 1'b0;
                check("clr_part", bad, 0);
                return;
            end
            if (i == 2) vsync = 1'b0;
            active_area = (i == overrun_at);
            tick();
            if (bus.clr_we !== 1'b1 || bus.clr_addr !== 9'(i) ||
                bus.addr_valid !== 1'b0 || frame_start !== 1'b0) bad++;
        end
        active_area = 1'b0;
        tick();
        check("clr_seq", bad, 0);
        check("clr_end", bus.clr_we, 0);
        check("busy_armed", busy, 1);
    endtask

    task automatic drive_pixels(input int n, input int cfg_at, output int bad,
                                output int nvalid, output int ndone, output int done_idx);
        bad = 0; nvalid = 0; ndone = 0; done_idx = -1;
        for (int p = 0; p < n; p++) begin
            active_area = 1'b1;
            if (p == cfg_at) begin
                bus.cfg_valid  = 1'b1;
                bus.cfg_enable = 1'b1;
            end
            tick();
            sample(bad, nvalid, ndone, done_idx);
            if (p == cfg_at) begin
                bus.cfg_valid = 1'b0;
                tick();
                check("cfg_ready_drop", bus.cfg_ready, 0);
                check("fe_hold", filter_enable, 0);
                sample(bad, nvalid, ndone, done_idx);
            end else if (p % 8 == 7) begin
                active_area = 1'b0;
                tick();
                sample(bad, nvalid, ndone, done_idx);
            end
        end
        active_area = 1'b0;
        tick();
        sample(bad, nvalid, ndone, done_idx);
    endtask

    initial begin
        int bad, nvalid, ndone, done_idx;
        rst_n          = 1'b0;
        vsync          = 1'b0;
        active_area    = 1'b0;
        bus.cfg_valid  = 1'b0;
        bus.cfg_enable = 1'b0;
        repeat (3) tick();
        check("rst_cfg_ready", bus.cfg_ready, 1);
        check("rst_fe", filter_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_clr_we", bus.clr_we, 0);
        check("rst_addr_valid", bus.addr_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_overrun", clr_overrun, 0);
        check("rst_pixel_addr", bus.pixel_addr, 0);
`ifdef FILTER_FRAME_CNT_EN
        check("rst_frame_count", frame_count, 0);
`endif
        rst_n = 1'b1;
        active_area = 1'b1;
        tick();
        tick();
        check("idle_mask", bus.addr_valid, 0);
        check("idle_busy", busy, 0);
        active_area = 1'b0;
        tick();

        // Frame A: full frame with gaps, config request mid-frame
        vsync_clear(-1, -1, 1'b0);
        check("overrun_clean", clr_overrun, 0);
        drive_pixels(NPIX, 1000, bad, nvalid, ndone, done_idx);
        check("pix_seq", bad, 0);
        check("pix_count", nvalid, NPIX);
        check("done_count", ndone, 1);
        check("done_at_last", done_idx, NPIX);
        check("busy_after_done", busy, 0);
        check("fe_still_0", filter_enable, 0);
        check("cfg_pending", bus.cfg_ready, 0);
`ifdef FILTER_FRAME_CNT_EN
        check("frame_count_1", frame_count, 1);
`endif

        // Frame B: pending enable lands, overrun during clear, aborted after 1000 pixels
        vsync_clear(-1, 100, 1'b1);
        check("overrun_set", clr_overrun, 1);
        drive_pixels(1000, -1, bad, nvalid, ndone, done_idx);
        check("abort_seq", bad, 0);
        check("abort_count", nvalid, 1000);
        check("abort_no_done", ndone, 0);

        // Frame C: handshake coincident with vsync rise, clear interrupted at cycle 50
        bus.cfg_valid  = 1'b1;
        bus.cfg_enable = 1'b0;
        vsync_clear(50, -1, 1'b0);
`ifdef FILTER_FRAME_CNT_EN
        check("frame_count_abort", frame_count, 1);
`endif

        // Frame D: clear restarts from 0, addressing restarts at {0,0}
        vsync_clear(-1, -1, 1'b0);
        drive_pixels(20, -1, bad, nvalid, ndone, done_idx);
        check("restart_seq", bad, 0);
        check("restart_count", nvalid, 20);
        check("overrun_sticky", clr_overrun, 1);
        check("fe_final", filter_enable, 0);

        rst_n = 1'b0;
        #1;
        check("rst2_overrun", clr_overrun, 0);
        check("rst2_cfg_ready", bus.cfg_ready, 1);
        check("rst2_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_filter_frame_ctrl.md
Name: noise_filter_frame_ctrl

Overview:
Frame-level sequencer for the RGB888 noise-filter datapath.
- Detects frame boundaries on vsync and clears the filter line buffer through a dedicated write port.
- Generates the raster pixel address ({y,x}) for active pixels.
- Applies filter-enable configuration only at frame boundaries, via a valid/ready shadow register.
- Sits between the VGA timing generator and the filter; it owns sequencing, while the filter stays purely a datapath.

Parameters:
H_PIXELS, 320, active pixels per line; x range 0..H_PIXELS-1
V_LINES, 240, active lines per frame; y range 0..V_LINES-1
CLR_DEPTH, 320, line-buffer entries to zero per frame

Ports:
clk  in  1  pixel clock (25 MHz)
rst_n  in  1  asynchronous active-low reset
vsync  in  1  vertical sync from timing generator, active high
active_area  in  1  high for each source pixel cycle
cfg_valid  in  1  config request valid
cfg_enable  in  1  requested filter enable value
cfg_ready  out  1  config shadow register free
filter_enable  out  1  enable driven to filter, frame-stable
pixel_addr  out  17  {y[7:0], x[8:0]}
addr_valid  out  1  pixel_addr qualifies the current pixel
clr_we  out  1  line-buffer clear write strobe
clr_addr  out  9  line-buffer clear address
frame_start  out  1  one-cycle pulse at each accepted vsync rise
frame_done  out  1  one-cycle pulse after the last pixel (x=H_PIXELS-1, y=V_LINES-1)
clr_overrun  out  1  sticky: active_area seen while clearing
busy  out  1  state != IDLE

Behaviour:
Reset (rst_n=0, async):
- state=IDLE.
- All outputs 0 except cfg_ready=1.
- filter_enable=0, shadow empty, x=y=0, vsync_d=0.

Vsync edge:
- vsync_rise = vsync & ~vsync_d, with vsync_d registered each cycle.

States:
- IDLE: on vsync_rise -> CLEAR.
- CLEAR:
  - clr_we=1; clr_addr counts 0..CLR_DEPTH-1, one per cycle.
  - After writing CLR_DEPTH-1 -> ARMED. Duration is exactly CLR_DEPTH cycles.
- ARMED: first active_area cycle -> RUN; that pixel is addressed as x=0, y=0.
- RUN:
  - Each active_area cycle: addr_valid=1, pixel_addr={y,x}, then x++.
  - If x=H_PIXELS-1: x<=0, y++.
  - Active-low gaps hold the counters.
  - Last pixel (x=H_PIXELS-1, y=V_LINES-1): frame_done=1 next cycle -> IDLE.

On every vsync_rise in any state:
- frame_start=1 next cycle.
- filter_enable <= shadow if pending; pending cleared.
- x=y=0, clr_addr=0, state -> CLEAR.
- In ARMED/RUN this aborts the frame; frame_done is not pulsed.
- Vsync_rise during CLEAR restarts the clear from address 0.

Timing:
- pixel_addr/addr_valid registered, 1-cycle latency from active_area.
- Same for clr_we/clr_addr from the state.

Masking:
- active_area in IDLE or CLEAR: addr_valid=0.
- active_area in CLEAR additionally sets clr_overrun.
- clr_overrun clears only on reset.

Config:
- cfg_ready = ~pending.
- Handshake = cfg_valid & cfg_ready: shadow<=cfg_enable, pending<=1.
- A handshake in the same cycle as vsync_rise applies at that boundary: filter_enable<=cfg_enable, pending stays 0.
- filter_enable never changes except at vsync_rise.

Widths:
- x 9 bits, y 8 bits, clr_addr 9 bits.
- No counter exceeds its parameter bound; y never wraps within a frame.

Optional Feature:
FILTER_FRAME_CNT_EN
- Defined: adds output frame_count[15:0].
  - Reset 0; increments on each frame_done; wraps 0xFFFF->0.
  - Aborted frames are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
Package noise_filter_ctrl_pkg holds:
- State enum (IDLE, CLEAR, ARMED, RUN).
- Default H_PIXELS/V_LINES/CLR_DEPTH.
- X_W=9, Y_W=8, ADDR_W=17, and the pixel_addr packing function.

One sub-module is natural: raster_addr_counter (x/y counters with wrap, hold and sync-clear), instantiated once.

Test Plan:
- Reset then vsync pulse -> frame_start 1 cycle; clr_we high exactly 320 cycles, clr_addr 0..319; then state ARMED.
- After the clear, drive 320x240 active pixels with 1-cycle gaps every 8 pixels:
  - pixel_addr sequence {0,0}..{0,319},{1,0}..{239,319}, all with addr_valid.
  - frame_done one cycle after {239,319}; busy=0.
- cfg_valid=1, cfg_enable=1 mid-frame:
  - cfg_ready drops; filter_enable stays 0 until the next vsync rise, then 1.
  - cfg_ready returns to 1.
- cfg handshake coincident with vsync_rise -> filter_enable takes the new value at that boundary; cfg_ready stays 1.
- vsync rise after 1000 RUN pixels:
  - No frame_done; clear restarts at clr_addr 0.
  - Next frame addresses from {0,0}.
- active_area during clear cycle 100:
  - addr_valid stays 0; clr_overrun=1 and remains set across later frames until rst_n.
  - With FILTER_FRAME_CNT_EN: frame_count=1 after one full frame, unchanged after an aborted frame.
